// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and widths for the register-file write arbiter.
package rf_arb_pkg;
    localparam int RF_ARB_DEPTH = 2;
    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W = $clog2(RF_ARB_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;
    function automatic logic [31:0] onehot(input logic [REG_W-1:0] r);
        return 32'd1 << r;
    endfunction
endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: 2-entry compacting FIFO of buffered MDU writes with squash by register
// and a registered pending-register mask. Valid entries always form a prefix (slot 0 = head).
module rf_arb_fifo
    import rf_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              squash,
    input  logic [REG_W-1:0]  squash_reg,
    input  logic              deq,
    input  logic              enq,
    input  logic [REG_W-1:0]  enq_reg,
    input  logic [DATA_W-1:0] enq_data,
    output logic              head_valid,
    output logic [REG_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic              head_squash,
    output logic [CNT_W-1:0]  count,
    output logic [31:0]       pend_mask
);
    entry_t q0, q1, n0, n1, ent;
    logic k0, k1;

    always_comb begin
        ent = '{valid: 1'b1, rd: enq_reg, data: enq_data};
        k0 = q0.valid && !deq && !(squash && q0.rd == squash_reg);
        k1 = q1.valid && !(squash && q1.rd == squash_reg);
        n0 = k0 ? q0 : k1 ? q1 : enq ? ent : '0;
        n1 = (k0 && k1) ? q1 : ((k0 ^ k1) && enq) ? ent : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
            pend_mask <= '0;
        end else begin
            q0 <= n0;
            q1 <= n1;
            pend_mask <= (n0.valid ? onehot(n0.rd) : 32'd0) | (n1.valid ? onehot(n1.rd) : 32'd0);
        end
    end

    assign head_valid = q0.valid;
    assign head_reg = q0.rd;
    assign head_data = q0.data;
    assign head_squash = squash && q0.valid && q0.rd == squash_reg;
    assign count = CNT_W'(q0.valid) + CNT_W'(q1.valid);
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: merges pipeline write-back and buffered MDU results onto one RF write port.
// Define RF_ARB_STARVE_EN to build the starvation FSM that drives Stall_Req.
module regfile_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WB_RegWrite,
    input  logic [REG_W-1:0]  WB_WriteRegister,
    input  logic [DATA_W-1:0] WB_WriteData,
    input  logic              MDU_Valid,
    output logic              MDU_Ready,
    input  logic [REG_W-1:0]  MDU_WriteRegister,
    input  logic [DATA_W-1:0] MDU_WriteData,
    output logic              RF_RegWrite,
    output logic [REG_W-1:0]  RF_WriteRegister,
    output logic [DATA_W-1:0] RF_WriteData,
    output logic              Stall_Req,
    output logic [31:0]       Pend_Mask
);
    logic wb_act, mdu_nz, bypass, by_wr, enq;
    logic head_valid, head_squash;
    logic [REG_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0] count;

    assign wb_act = WB_RegWrite && WB_WriteRegister != '0;
    assign mdu_nz = MDU_WriteRegister != '0;
    assign MDU_Ready = count < CNT_W'(RF_ARB_DEPTH);
    assign bypass = !head_valid && !wb_act && MDU_Valid;
    assign by_wr = bypass && mdu_nz;
    // r0 results are handshaken but dropped: never enqueued, never written
    assign enq = MDU_Valid && MDU_Ready && !bypass && mdu_nz;

    assign RF_RegWrite = wb_act || head_valid || by_wr;
    assign RF_WriteRegister = wb_act ? WB_WriteRegister : head_valid ? head_reg : by_wr ? MDU_WriteRegister : '0;
    assign RF_WriteData = wb_act ? WB_WriteData : head_valid ? head_data : by_wr ? MDU_WriteData : '0;

    rf_arb_fifo u_fifo (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .squash     (wb_act),
        .squash_reg (WB_WriteRegister),
        .deq        (!wb_act),
        .enq        (enq),
        .enq_reg    (MDU_WriteRegister),
        .enq_data   (MDU_WriteData),
        .head_valid (head_valid),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .head_squash(head_squash),
        .count      (count),
        .pend_mask  (Pend_Mask)
    );

`ifdef RF_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic waiting;

    // the first waiting cycle is counted on the IDLE->WAIT transition
    assign waiting = head_valid && wb_act && !head_squash;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cnt_inc = cnt + 1'b1;
        if (!waiting) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (state == IDLE) begin
            state_n = WAIT;
            cnt_n = CW'(1);
        end else if (state == WAIT) begin
            cnt_n = cnt_inc;
            state_n = (cnt_inc == CW'(STARVE_LIMIT)) ? STALL : WAIT;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    assign Stall_Req = state == STALL;
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;
    assign Stall_Req = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed self-checking bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
`ifdef RF_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    logic        Clk, Rst_n;
    logic        WB_RegWrite, MDU_Valid, MDU_Ready, RF_RegWrite, Stall_Req;
    logic [4:0]  WB_WriteRegister, MDU_WriteRegister, RF_WriteRegister;
    logic [31:0] WB_WriteData, MDU_WriteData, RF_WriteData, Pend_Mask;
    int total = 0;
    int bad = 0;

    regfile_wr_arbiter #(.STARVE_LIMIT(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
        .MDU_Valid(MDU_Valid), .MDU_Ready(MDU_Ready),
        .MDU_WriteRegister(MDU_WriteRegister), .MDU_WriteData(MDU_WriteData),
        .RF_RegWrite(RF_RegWrite), .RF_WriteRegister(RF_WriteRegister), .RF_WriteData(RF_WriteData),
        .Stall_Req(Stall_Req), .Pend_Mask(Pend_Mask)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // advance to 1ns after the next rising edge
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // apply one cycle's inputs and let combinational outputs settle
    task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        WB_RegWrite = wv; WB_WriteRegister = wr; WB_WriteData = wd;
        MDU_Valid = mv; MDU_WriteRegister = mr; MDU_WriteData = md;
        #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        total++; if (MDU_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", MDU_Ready); end
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL reset_mask: got %h want 0", Pend_Mask); end
        total++; if (Stall_Req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", Stall_Req); end
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== 38'd0) begin bad++;
            $display("FAIL reset_rf: got %b/%0d/%h want 0/0/0", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick; tick;
        Rst_n = 1'b1;
        tick;
    endtask

    task automatic test_wb_vs_mdu;
        drive(1, 5, 32'hA, 1, 6, 32'hB);
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd5, 32'hA}) begin bad++;
            $display("FAIL wb_prio: got %b/%0d/%h want 1/5/a", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (Pend_Mask !== 32'h40) begin bad++; $display("FAIL wb_vs_mdu_mask: got %h want 40", Pend_Mask); end
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd6, 32'hB}) begin bad++;
            $display("FAIL drain_r6: got %b/%0d/%h want 1/6/b", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL drained_mask: got %h want 0", Pend_Mask); end
        total++; if (RF_RegWrite !== 1'b0) begin bad++; $display("FAIL drained_idle: got %b want 0", RF_RegWrite); end
    endtask

    task automatic test_bypass;
        drive(0, 0, 0, 1, 7, 32'h1234);
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd7, 32'h1234}) begin bad++;
            $display("FAIL bypass_rf: got %b/%0d/%h want 1/7/1234", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL bypass_mask: got %h want 0", Pend_Mask); end
        total++; if (RF_RegWrite !== 1'b0) begin bad++; $display("FAIL bypass_no_replay: got %b want 0", RF_RegWrite); end
        tick;
    endtask

    task automatic test_starve;
        drive(1, 1, 32'h1, 1, 10, 32'h100);
        tick;
        drive(1, 2, 32'h2, 1, 11, 32'h200);
        total++; if (MDU_Ready !== 1'b1) begin bad++; $display("FAIL starve_ready1: got %b want 1", MDU_Ready); end
        tick;
        for (int i = 0; i < 7; i++) begin
            drive(1, 3, 32'h3, 0, 0, 0);
            total++; if (Stall_Req !== 1'b0) begin bad++; $display("FAIL starve_early_stall%0d: got %b want 0", i, Stall_Req); end
            if (i == 0) begin
                total++; if (MDU_Ready !== 1'b0) begin bad++; $display("FAIL starve_full_ready: got %b want 0", MDU_Ready); end
                total++; if (Pend_Mask !== 32'h0C00) begin bad++; $display("FAIL starve_mask: got %h want c00", Pend_Mask); end
            end
            tick;
        end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (Stall_Req !== STARVE) begin bad++; $display("FAIL starve_stall: got %b want %b", Stall_Req, STARVE); end
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd10, 32'h100}) begin bad++;
            $display("FAIL bubble_r10: got %b/%0d/%h want 1/10/100", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        drive(1, 4, 32'h4, 0, 0, 0);
        total++; if (Stall_Req !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b want 0", Stall_Req); end
        total++; if (Pend_Mask !== 32'h0800) begin bad++; $display("FAIL after_bubble_mask: got %h want 800", Pend_Mask); end
        total++; if (MDU_Ready !== 1'b1) begin bad++; $display("FAIL after_bubble_ready: got %b want 1", MDU_Ready); end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd11, 32'h200}) begin bad++;
            $display("FAIL drain_r11: got %b/%0d/%h want 1/11/200", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL starve_empty_mask: got %h want 0", Pend_Mask); end
    endtask

    task automatic test_squash;
        drive(1, 1, 32'h1, 1, 9, 32'h99);
        tick;
        drive(1, 9, 32'h55, 0, 0, 0);
        total++; if (Pend_Mask !== 32'h200) begin bad++; $display("FAIL squash_pend: got %h want 200", Pend_Mask); end
        total++; if ({RF_RegWrite, RF_WriteRegister, RF_WriteData} !== {1'b1, 5'd9, 32'h55}) begin bad++;
            $display("FAIL squash_wb: got %b/%0d/%h want 1/9/55", RF_RegWrite, RF_WriteRegister, RF_WriteData); end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL squash_mask%0d: got %h want 0", i, Pend_Mask); end
            total++; if (RF_RegWrite !== 1'b0) begin bad++;
                $display("FAIL squash_no_write%0d: got %b/%0d want 0", i, RF_RegWrite, RF_WriteRegister); end
            tick;
        end
    endtask

    task automatic test_r0;
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        total++; if (MDU_Ready !== 1'b1) begin bad++; $display("FAIL r0_ready: got %b want 1", MDU_Ready); end
        total++; if (RF_RegWrite !== 1'b0) begin bad++; $display("FAIL r0_bypass_write: got %b want 0", RF_RegWrite); end
        tick;
        drive(1, 1, 32'h1, 1, 0, 32'hBEEF);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL r0_mask: got %h want 0", Pend_Mask); end
        total++; if (RF_RegWrite !== 1'b0) begin bad++; $display("FAIL r0_queued_write: got %b want 0", RF_RegWrite); end
        tick;
    endtask

    task automatic test_reset_mid;
        drive(1, 1, 32'h1, 1, 12, 32'hC);
        tick;
        drive(1, 2, 32'h2, 1, 13, 32'hD);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (MDU_Ready !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", MDU_Ready); end
        total++; if (Pend_Mask !== 32'h3000) begin bad++; $display("FAIL mid_mask_pre: got %h want 3000", Pend_Mask); end
        Rst_n = 1'b0;
        #1;
        total++; if (MDU_Ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", MDU_Ready); end
        total++; if (Pend_Mask !== 32'd0) begin bad++; $display("FAIL mid_mask: got %h want 0", Pend_Mask); end
        total++; if (RF_RegWrite !== 1'b0) begin bad++; $display("FAIL mid_rf_in_reset: got %b want 0", RF_RegWrite); end
        tick;
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (RF_RegWrite !== 1'b0) begin bad++;
                $display("FAIL mid_no_write%0d: got %b/%0d want 0", i, RF_RegWrite, RF_WriteRegister); end
        end
    endtask

    initial begin
        test_reset;
        test_wb_vs_mdu;
        test_bypass;
        test_starve;
        test_squash;
        test_r0;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: cycles a buffered MDU write may wait before Stall_Req asserts.
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port WB_RegWrite  input  1  pipeline write-back request; never back-pressured.
REQ-005 SHALL have port WB_WriteRegister  input  5  write-back destination.
REQ-006 SHALL have port WB_WriteData  input  32  write-back data.
REQ-007 SHALL have port MDU_Valid  input  1  multi-cycle unit result valid.
REQ-008 SHALL have port MDU_Ready  output  1  arbiter can accept the MDU result.
REQ-009 SHALL have port MDU_WriteRegister  input  5  MDU destination.
REQ-010 SHALL have port MDU_WriteData  input  32  MDU data.
REQ-011 SHALL have port RF_RegWrite  output  1  register-file write enable.
REQ-012 SHALL have port RF_WriteRegister  output  5  register-file write address.
REQ-013 SHALL have port RF_WriteData  output  32  register-file write data.
REQ-014 SHALL have port Stall_Req  output  1  request that the pipeline insert a write-back bubble.
REQ-015 SHALL have port Pend_Mask  output  32  bit r set while a buffered write to register r is pending.

Function
REQ-016 SHALL hold MDU results in a 2-entry FIFO; MDU_Ready = (count < 2), combinational from state only.
REQ-017 SHALL treat a WB request as active only when WB_RegWrite=1 and WB_WriteRegister != 0.
REQ-018 SHALL drive the RF_* outputs combinationally, with zero latency, by priority: active WB; else FIFO head; else a direct MDU bypass.
REQ-019 SHALL take the direct bypass only when the FIFO is empty, WB is not active and MDU_Valid=1; the bypass writes without enqueuing.
REQ-020 SHALL enqueue the MDU result on MDU_Valid & MDU_Ready when the bypass is not taken.
REQ-021 SHALL accept MDU results whose destination is register 0 and SHALL discard them: neither enqueued nor written.
REQ-022 SHALL dequeue the FIFO head in any cycle where WB is not active.
REQ-023 SHALL invalidate (squash) every FIFO entry whose register equals an active WB_WriteRegister in that cycle, because the WB write is program-order younger.
REQ-024 SHALL allow enqueue and dequeue in the same cycle; the count is then unchanged.
REQ-025 SHALL drive RF_RegWrite=0 and RF_WriteRegister/RF_WriteData=0 when no source is selected.
REQ-026 SHALL compute Pend_Mask as the OR of one-hot decodes of the valid FIFO entries, registered, so it reflects post-edge state.
REQ-027 Starvation FSM SHALL have states IDLE, WAIT and STALL.
  - IDLE -> WAIT when the head is valid and not dequeued.
  - WAIT increments a counter each cycle; WAIT -> STALL when the counter reaches STARVE_LIMIT.
  - Any dequeue or squash of the head -> IDLE, counter cleared.
REQ-028 SHALL assert Stall_Req=1 only in STALL.

Reset
REQ-029 On Rst_n=0, SHALL immediately force: FIFO empty, count=0, FSM=IDLE, counter=0, Pend_Mask=0, Stall_Req=0, MDU_Ready=1.
REQ-030 Reset mid-operation SHALL drop all buffered writes; no RF write is generated for them.

Configuration
REQ-031 Macro RF_ARB_STARVE_EN SHALL control the starvation logic.
  - Defined: the FSM and counter are built and REQ-027/028 apply.
  - Undefined: no FSM or counter is built, Stall_Req is tied 0, and all other behaviour is unchanged.

Structure
REQ-032 Shared package rf_arb_pkg SHALL hold the FSM state enum, RF_ARB_DEPTH=2, and the register-index/data width constants (5, 32).
REQ-033 The FIFO with squash and mask output SHALL be sub-module rf_arb_fifo; the arbitration mux and FSM SHALL stay at top level.

Verification
REQ-034 Bench SHALL cover: WB write r5=0xA, MDU_Valid r6=0xB simultaneously, FIFO empty -> RF writes r5; r6 enqueued; Pend_Mask=0x40; next idle cycle RF writes r6=0xB.
REQ-035 Bench SHALL cover: FIFO empty, WB idle, MDU r7=0x1234 -> same-cycle RF write r7; Pend_Mask stays 0.
REQ-036 Bench SHALL cover: WB active every cycle, two MDU results -> MDU_Ready=0 at count=2; after 8 waiting cycles Stall_Req=1; first WB bubble drains the head and Stall_Req=0.
REQ-037 Bench SHALL cover: FIFO holds r9, WB writes r9=0x55 -> entry squashed; Pend_Mask bit 9 clears; no later RF write to r9.
REQ-038 Bench SHALL cover: MDU result to r0 -> accepted, never written, Pend_Mask=0.
REQ-039 Bench SHALL cover: Rst_n pulled low with 2 entries buffered -> count=0, Pend_Mask=0, and no RF write after release.
